// File: rtl/pc_sequencer.sv
// Fetch-stage program-counter sequencer with redirect, jump and call/return.
// The return-address stack is a circular buffer, so a call into a full stack overwrites the oldest entry.
module pc_sequencer #(
   parameter int unsigned       ADDR_W     = 5,
   parameter int unsigned       RAS_DEPTH  = 4,
   parameter logic [ADDR_W-1:0] RESET_ADDR = '0
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              ce_i,
   input  logic              fetch_ready_i,
   input  logic              redirect_valid_i,
   input  logic [ADDR_W-1:0] redirect_addr_i,
   input  logic              jump_valid_i,
   input  logic [ADDR_W-1:0] jump_addr_i,
   input  logic              call_i,
   input  logic              ret_i,
   output logic [ADDR_W-1:0] pc_o,
   output logic              pc_valid_o,
   output logic              ras_empty_o,
   output logic              ras_full_o,
   output logic              ras_underflow_o
);

   localparam int unsigned PTR_W = (RAS_DEPTH > 1) ? $clog2(RAS_DEPTH) : 1;
   localparam int unsigned CNT_W = $clog2(RAS_DEPTH + 1);

   logic [ADDR_W-1:0] pc_q, pc_d;
   logic              valid_q, valid_d;
   logic [CNT_W-1:0]  cnt_q, cnt_d;
   logic [PTR_W-1:0]  ptr_q, ptr_d;
   logic              under_q, under_d;
   logic [ADDR_W-1:0] ras_q [RAS_DEPTH];

   logic              rasWe;
   logic [PTR_W-1:0]  rasWaddr;
   logic [ADDR_W-1:0] pcInc;
   logic [PTR_W-1:0]  topIdx;
   logic [PTR_W-1:0]  ptrInc;
   logic              rasEmpty;
   logic              rasFull;

   // ptr_q is the next free slot; the top of stack sits one slot behind it
   assign pcInc    = pc_q + ADDR_W'(1);
   assign topIdx   = (ptr_q == '0) ? PTR_W'(RAS_DEPTH - 1) : ptr_q - PTR_W'(1);
   assign ptrInc   = (ptr_q == PTR_W'(RAS_DEPTH - 1)) ? '0 : ptr_q + PTR_W'(1);
   assign rasEmpty = (cnt_q == '0);
   assign rasFull  = (cnt_q == CNT_W'(RAS_DEPTH));

   always_comb begin
      pc_d     = pc_q;
      valid_d  = valid_q;
      cnt_d    = cnt_q;
      ptr_d    = ptr_q;
      under_d  = 1'b0;
      rasWe    = 1'b0;
      rasWaddr = ptr_q;
      if (ce_i) begin
         if (!valid_q) begin
            valid_d = 1'b1;
         end else if (redirect_valid_i) begin
            pc_d = redirect_addr_i;
         end else if (fetch_ready_i) begin
            if (ret_i && !rasEmpty) begin
               pc_d = ras_q[topIdx];
               if (call_i) begin
                  // call+ret swaps the top for the new return address
                  rasWe    = 1'b1;
                  rasWaddr = topIdx;
               end else begin
                  ptr_d = topIdx;
                  cnt_d = cnt_q - CNT_W'(1);
               end
            end else if (ret_i && !call_i) begin
               pc_d    = pcInc;
               under_d = 1'b1;
            end else if (call_i) begin
               rasWe    = 1'b1;
               rasWaddr = ptr_q;
               ptr_d    = ptrInc;
               pc_d     = jump_addr_i;
               if (!rasFull) cnt_d = cnt_q + CNT_W'(1);
            end else if (jump_valid_i) begin
               pc_d = jump_addr_i;
            end else begin
               pc_d = pcInc;
            end
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         pc_q    <= RESET_ADDR;
         valid_q <= 1'b0;
         cnt_q   <= '0;
         ptr_q   <= '0;
         under_q <= 1'b0;
      end else begin
         pc_q    <= pc_d;
         valid_q <= valid_d;
         cnt_q   <= cnt_d;
         ptr_q   <= ptr_d;
         under_q <= under_d;
      end
   end

   // Stack contents are don't-care after reset, so the array carries no reset
   always_ff @(posedge clk) begin
      if (rasWe) ras_q[rasWaddr] <= pcInc;
   end

   assign pc_o            = pc_q;
   assign pc_valid_o      = valid_q;
   assign ras_empty_o     = rasEmpty;
   assign ras_full_o      = rasFull;
   assign ras_underflow_o = under_q;

endmodule

// File: tb/tb_pc_sequencer.sv
// Self-checking bench for pc_sequencer: directed scenarios plus random traffic,
// compared against a queue-based model of the sequencing rules.
module tb_pc_sequencer;

   localparam int ADDR_W    = 5;
   localparam int RAS_DEPTH = 4;
   localparam int MOD       = 1 << ADDR_W;

   logic              clk = 1'b0;
   logic              rst_n = 1'b0;
   logic              ce = 1'b0;
   logic              fetchReady = 1'b0;
   logic              redirectValid = 1'b0;
   logic [ADDR_W-1:0] redirectAddr = '0;
   logic              jumpValid = 1'b0;
   logic [ADDR_W-1:0] jumpAddr = '0;
   logic              callReq = 1'b0;
   logic              retReq = 1'b0;
   logic [ADDR_W-1:0] pc;
   logic              pcValid;
   logic              rasEmpty;
   logic              rasFull;
   logic              rasUnderflow;

   int testsRun = 0;
   int testsFailed = 0;

   // Reference model state
   int mPc = 0;
   int mValid = 0;
   int mUnder = 0;
   int mRas[$];

   pc_sequencer #(
      .ADDR_W(ADDR_W),
      .RAS_DEPTH(RAS_DEPTH),
      .RESET_ADDR('0)
   ) dut (
      .clk(clk),
      .rst_n(rst_n),
      .ce_i(ce),
      .fetch_ready_i(fetchReady),
      .redirect_valid_i(redirectValid),
      .redirect_addr_i(redirectAddr),
      .jump_valid_i(jumpValid),
      .jump_addr_i(jumpAddr),
      .call_i(callReq),
      .ret_i(retReq),
      .pc_o(pc),
      .pc_valid_o(pcValid),
      .ras_empty_o(rasEmpty),
      .ras_full_o(rasFull),
      .ras_underflow_o(rasUnderflow)
   );

   always #5 clk = ~clk;

   task automatic checkOutput(input string tag, input int observed, input int expected);
      testsRun++;
      if (observed !== expected) begin
         testsFailed++;
         $display("[TB] FAIL %s: got %0d, expected %0d (t=%0t)", tag, observed, expected, $time);
      end
   endtask

   task automatic checkAll(input string tag);
      checkOutput({tag, ".pc"}, int'(pc), mPc);
      checkOutput({tag, ".pc_valid"}, int'(pcValid), mValid);
      checkOutput({tag, ".ras_empty"}, int'(rasEmpty), (mRas.size() == 0) ? 1 : 0);
      checkOutput({tag, ".ras_full"}, int'(rasFull), (mRas.size() == RAS_DEPTH) ? 1 : 0);
      checkOutput({tag, ".ras_underflow"}, int'(rasUnderflow), mUnder);
   endtask

   // Model of one rising edge, expressed directly from the priority rules
   task automatic modelEdge();
      int t;
      mUnder = 0;
      if (!ce) return;
      if (mValid == 0) begin
         mValid = 1;
         return;
      end
      if (redirectValid) begin
         mPc = int'(redirectAddr);
      end else if (fetchReady) begin
         if (callReq && retReq && mRas.size() > 0) begin
            t = mRas.pop_back();
            mRas.push_back((mPc + 1) % MOD);
            mPc = t;
         end else if (retReq && !callReq) begin
            if (mRas.size() > 0) begin
               mPc = mRas.pop_back();
            end else begin
               mPc = (mPc + 1) % MOD;
               mUnder = 1;
            end
         end else if (callReq) begin
            mRas.push_back((mPc + 1) % MOD);
            if (mRas.size() > RAS_DEPTH) void'(mRas.pop_front());
            mPc = int'(jumpAddr);
         end else if (jumpValid) begin
            mPc = int'(jumpAddr);
         end else begin
            mPc = (mPc + 1) % MOD;
         end
      end
   endtask

   task automatic applyStimulus(input string tag, input logic c, input logic fr,
                                input logic rv, input int ra, input logic jv,
                                input int ja, input logic cl, input logic rt);
      ce            = c;
      fetchReady    = fr;
      redirectValid = rv;
      redirectAddr  = ADDR_W'(ra);
      jumpValid     = jv;
      jumpAddr      = ADDR_W'(ja);
      callReq       = cl;
      retReq        = rt;
      @(posedge clk);
      modelEdge();
      #1;
      checkAll(tag);
   endtask

   // Asynchronous reset pulse placed between clock edges
   task automatic pulseReset(input string tag);
      rst_n = 1'b0;
      #2;
      mPc = 0;
      mValid = 0;
      mUnder = 0;
      mRas.delete();
      checkAll(tag);
      #2;
      rst_n = 1'b1;
   endtask

   initial begin
      #3;
      mPc = 0;
      mValid = 0;
      checkAll("reset");
      #4;
      rst_n = 1'b1;

      // Straight-line fetch through the address wrap
      for (int i = 0; i < 34; i++) applyStimulus("seq", 1, 1, 0, 0, 0, 0, 0, 0);
      checkOutput("seq.wrap_end", int'(pc), 1);

      // Stall at 7, then redirect while still stalled
      applyStimulus("to7", 1, 0, 1, 7, 0, 0, 0, 0);
      for (int i = 0; i < 3; i++) applyStimulus("stall", 1, 0, 0, 0, 0, 0, 0, 0);
      checkOutput("stall.hold", int'(pc), 7);
      applyStimulus("redir", 1, 0, 1, 20, 0, 0, 0, 0);
      checkOutput("redir.target", int'(pc), 20);

      // Nested call / return
      applyStimulus("to3", 1, 1, 1, 3, 0, 0, 0, 0);
      applyStimulus("call1", 1, 1, 0, 0, 0, 10, 1, 0);
      checkOutput("call1.pc", int'(pc), 10);
      applyStimulus("call2", 1, 1, 0, 0, 0, 16, 1, 0);
      checkOutput("call2.pc", int'(pc), 16);
      applyStimulus("ret1", 1, 1, 0, 0, 0, 0, 0, 1);
      checkOutput("ret1.pc", int'(pc), 11);
      applyStimulus("ret2", 1, 1, 0, 0, 0, 0, 0, 1);
      checkOutput("ret2.pc", int'(pc), 4);
      checkOutput("ret2.empty", int'(rasEmpty), 1);

      // Overfill the stack and drain it past empty
      applyStimulus("to1", 1, 1, 1, 1, 0, 0, 0, 0);
      for (int i = 0; i < 5; i++) begin
         applyStimulus("fill", 1, 1, 0, 0, 0, i + 2, 1, 0);
         if (i == 3) checkOutput("fill.full4", int'(rasFull), 1);
      end
      for (int i = 0; i < 4; i++) begin
         applyStimulus("drain", 1, 1, 0, 0, 0, 0, 0, 1);
         checkOutput("drain.pc", int'(pc), 6 - i);
      end
      applyStimulus("uflow", 1, 1, 0, 0, 0, 0, 0, 1);
      checkOutput("uflow.pc", int'(pc), 4);
      checkOutput("uflow.pulse", int'(rasUnderflow), 1);
      applyStimulus("uflow_end", 1, 1, 0, 0, 0, 0, 0, 0);
      checkOutput("uflow.once", int'(rasUnderflow), 0);

      // call+ret swap, then redirect beating call
      applyStimulus("to11", 1, 1, 1, 11, 0, 0, 0, 0);
      applyStimulus("push12", 1, 1, 0, 0, 0, 25, 1, 0);
      applyStimulus("to8", 1, 1, 1, 8, 0, 0, 0, 0);
      applyStimulus("swap", 1, 1, 0, 0, 0, 30, 1, 1);
      checkOutput("swap.pc", int'(pc), 12);
      applyStimulus("redir_call", 1, 1, 1, 17, 0, 5, 1, 0);
      checkOutput("redir_call.pc", int'(pc), 17);
      applyStimulus("ret_swap", 1, 1, 0, 0, 0, 0, 0, 1);
      checkOutput("ret_swap.pc", int'(pc), 9);

      // Clock enable low freezes everything, then async reset mid-cycle
      applyStimulus("pre_ce", 1, 1, 0, 0, 0, 0, 0, 1);
      for (int i = 0; i < 4; i++) applyStimulus("ce0", 0, 1, 1, 3, 1, 9, 1, 1);
      checkOutput("ce0.under_low", int'(rasUnderflow), 0);
      pulseReset("async_rst");
      checkOutput("async_rst.pc", int'(pc), 0);

      // Random traffic with occasional resets
      for (int i = 0; i < 600; i++) begin
         if ($urandom_range(0, 99) == 0) begin
            pulseReset("rnd_rst");
         end else begin
            applyStimulus("rnd",
                          ($urandom_range(0, 9) != 0),
                          ($urandom_range(0, 3) != 0),
                          ($urandom_range(0, 9) == 0),
                          int'($urandom_range(0, MOD - 1)),
                          ($urandom_range(0, 4) == 0),
                          int'($urandom_range(0, MOD - 1)),
                          ($urandom_range(0, 3) == 0),
                          ($urandom_range(0, 3) == 0));
         end
      end

      $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
      $finish;
   end

endmodule

// File: doc/pc_sequencer.md
# pc_sequencer

Parametrised program-counter sequencer for the fetch stage of the pipelined processor. Generates the instruction-memory word address each cycle, advancing sequentially under a fetch handshake, and supports branch-resolution redirect, jump, call/return via an internal return-address stack (RAS), and clock enable. It drives the instruction memory address port and the IF/ID register.

## Interface
- `ADDR_W`, 5: PC width in bits; word address, increment is 1.
- `RAS_DEPTH`, 4: return-address stack entries, must be ≥2.
- `RESET_ADDR`, 0: PC value loaded on reset.
- `clk`  in  1  clock; all state changes on the rising edge.
- `reset`  in  1  asynchronous, active-low reset.
- `ce`  in  1  clock enable; when 0 all state holds, including the RAS.
- `fetch_ready`  in  1  downstream accepts the current `pc` this cycle.
- `redirect_valid`  in  1  branch resolution override.
- `redirect_addr`  in  ADDR_W  redirect target.
- `jump_valid`  in  1  unconditional jump for the current `pc`.
- `jump_addr`  in  ADDR_W  jump target; also the call target.
- `call`  in  1  call: push `pc+1`, go to `jump_addr`.
- `ret`  in  1  return: pop RAS top into `pc`.
- `pc`  out  ADDR_W  current fetch address.
- `pc_valid`  out  1  `pc` is meaningful.
- `ras_empty`  out  1  RAS holds 0 entries.
- `ras_full`  out  1  RAS holds RAS_DEPTH entries.
- `ras_underflow`  out  1  one-cycle pulse: `ret` with an empty RAS.

## Operation
- Reset (`reset`=0) gives `pc`=RESET_ADDR, `pc_valid`=0, RAS count=0, `ras_empty`=1, `ras_full`=0, `ras_underflow`=0. RAS entry contents are don't-care.
- `pc_valid` rises at the first edge with `ce`=1 after reset is released. It then stays 1 until the next reset. `pc` does not advance on that edge.
- Fetch is accepted when `ce`, `pc_valid` and `fetch_ready` are all 1. `jump_valid`, `call` and `ret` are sampled only on an accepted fetch. Otherwise they are ignored, and the issuer holds them.
- Priority on each edge with `ce`=1 and `pc_valid`=1:
  1. `redirect_valid` (taken regardless of `fetch_ready`) sets `pc` to `redirect_addr`. The RAS is untouched and all other requests are dropped.
  2. `call` and `ret` together: `pc` becomes the RAS top, and the top is overwritten with the old `pc+1`. Count is unchanged. If the RAS is empty, this behaves as `call` alone.
  3. `ret` takes effect only if the count is >0. Then `pc` becomes the RAS top and the count decrements. If the RAS is empty, `pc` becomes `pc+1` and `ras_underflow` pulses.
  4. `call` pushes `pc+1` and sets `pc` to `jump_addr`. If the RAS is full, the oldest entry is discarded (circular buffer), the count stays at RAS_DEPTH, and no error is raised.
  5. `jump_valid` sets `pc` to `jump_addr`.
  6. On an accepted fetch with no other request, `pc` becomes `pc+1`.
  7. Otherwise (`fetch_ready`=0) `pc` holds.
- All `pc` arithmetic is modulo 2^ADDR_W, so `pc+1` from all-ones wraps to 0. This includes the pushed return address.
- `ras_empty` and `ras_full` are decoded from the registered count.

## Timing
- All outputs are registered or decoded from registers; there are no combinational input-to-output paths.
- Each control decision takes effect in `pc` one cycle later, so redirect-to-new-`pc` latency is 1 cycle.
- `ras_underflow` is high for exactly the cycle after the offending edge. It is forced low when `ce`=0 at an edge.
- Asserting `reset` in any cycle (including mid-call or mid-stall) immediately forces the reset values, without waiting for `clk`.
- Reset release is synchronised by the caller. The block needs only one `ce` edge to become valid.

## Test plan
- Reset, then `ce`=1 and `fetch_ready`=1 for 34 cycles -> `pc_valid` rises at edge 1 with `pc`=0. `pc` then counts 1…31, wraps to 0, then reaches 1.
- `fetch_ready`=0 for 3 cycles at `pc`=7, then `redirect_valid` with addr 20 while still not ready -> `pc` holds 7 for 3 cycles, then shows 20 one cycle after the redirect.
- Call at `pc`=3 to 10, call at `pc`=10 to 16, then `ret` twice -> `pc` sequence is 10, 16, 11, 4. `ras_empty` is 1 at the end.
- Five calls from `pc` 1, 2, 3, 4, 5 (each to `pc+1`), then four `ret`s -> `ras_full`=1 after the 4th call. The returns yield 6, 5, 4, 3 (return address 2 is discarded). A 5th `ret` gives `pc+1` and a one-cycle `ras_underflow` pulse.
- `call`+`ret` together at `pc`=8 with RAS top 12 -> `pc` becomes 12, the top becomes 9, and the count is unchanged. `redirect_valid`+`call` together -> `pc` is the redirect target and the RAS is unchanged.
- `ce`=0 for 4 cycles with all requests asserted -> all state is frozen. `reset` pulsed low between edges -> `pc` becomes 0 and `pc_valid` becomes 0 immediately.
